traffic_conflict_monitor: RTL
=============================

# traffic_conflict_monitor

Independent safety monitor on the light outputs of the intersection controller. It samples the 2-bit highway and street light codes every cycle and checks each sample for invalid codes, conflicting greens, illegal sequence steps, short yellows and stuck phases. On the first violation it latches a fault and a fault code, and keeps them until software clears it. The intersection top level wires its fault output to the flash-red override and to a status register.

## Interface
- MIN_YELLOW, 1: minimum cycles a yellow must be held before it goes to red.
- MAX_PHASE, 255: maximum cycles one combined light state may persist; must be < 2^CNT_W.
- CNT_W, 8: width of the dwell counter and the fault counter.

- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- highway  input  2  highway light code: 00 Red, 01 Green, 10 Yellow, 11 invalid.
- street  input  2  street light code, same encoding.
- clr_fault  input  1  single-cycle request to clear a latched fault.
- fault  output  1  latched fault flag.
- fault_code  output  3  code of the first violation: 0 none, 1 invalid code, 2 conflict, 3 illegal transition, 4 short yellow, 5 watchdog.
- dwell  output  CNT_W  cycles the current combined state has been held (saturating).
- fault_count  output  CNT_W  number of faults latched since reset (saturating); clr_fault does not clear it.

## Operation
- States:
  - INIT: first sample after reset or clear; no history yet.
  - MONITOR: all checks active.
  - FAULT: latched; no further checks.
- Registers:
  - prev: {highway,street} captured at the previous edge.
  - dwell: cycle count for the current combined state.
- Checks are combinational on the current inputs against prev and dwell. When more than one fires, the lowest code wins.
  - 1: either channel is 11.
  - 2: both channels are non-red (any Green/Yellow mix).
  - 3: a channel step outside the legal set: same value, G to Y, Y to R, R to G. G to R, Y to G and R to Y are illegal. MONITOR only.
  - 4: a channel goes Y to R while dwell < MIN_YELLOW. MONITOR only.
  - 5: inputs equal prev and dwell == MAX_PHASE. MONITOR only.
- INIT: only checks 1 and 2 apply.
  - On a violation, go to FAULT.
  - Otherwise load prev, set dwell to 1 and go to MONITOR.
- MONITOR:
  - On a violation, go to FAULT. fault is set, fault_code takes the winning code and fault_count increments, saturating at 2^CNT_W-1.
  - Otherwise load prev. dwell becomes 1 on a change, or dwell+1 (saturating) when unchanged.
- FAULT:
  - fault and fault_code hold; dwell keeps counting; prev keeps tracking the inputs.
  - clr_fault moves to INIT and clears fault and fault_code to 0.
- clr_fault outside FAULT has no effect. A violation present in the same cycle as a clear is ignored.
- All-red states of any length are legal; the controller's wrap-through-idle states are all red.

## Timing
- Reset values:
  - fault=0, fault_code=0, dwell=0, fault_count=0.
  - prev=00/00, state INIT.
- Reset mid-FAULT drops the fault immediately (asynchronous) but does not preserve fault_count.
- Latency: a violating sample present before edge N shows as fault=1 and a valid fault_code after edge N. There are no extra pipeline stages.
- clr_fault sampled at edge N: fault=0 after edge N. The next sample is checked as INIT.
- Watchdog: a state held continuously faults at the edge that would make dwell MAX_PHASE+1.
- dwell saturates at 2^CNT_W-1 and never wraps.
- Short-yellow comparison uses the dwell value before the edge. A yellow held exactly MIN_YELLOW cycles is legal.

## Structure
- Shared package traffic_pkg:
  - light code constants RED=2'b00, GREEN=2'b01, YELLOW=2'b10.
  - fault code constants FLT_NONE..FLT_WDOG (0..5).
  - monitor state encoding INIT/MONITOR/FAULT.
  - The controller uses the same light constants.
- Sub-module traffic_transition_check: per-channel legal-step check, taking prev code and current code and producing illegal and y2r flags. It is instantiated once for highway and once for street.

## Test plan
- Reset, then the controller cycle 01/00, 10/00, 00/01, 00/10 followed by 4 cycles of 00/00, repeated 3 times, with MIN_YELLOW=1 → fault stays 0, fault_count=0, dwell returns to 1 at every change.
- In MONITOR drive 01/01 → fault=1, code=2, fault_count=1 after that edge. Then drive 11/00 → code stays 2.
- Drive highway 01 then directly 00 (G to R) → code=3. Pulse clr_fault → fault=0 after that edge. Drive 11/00 on the next sample → code=1 (INIT check).
- MIN_YELLOW=3: hold 10/00 for 2 cycles then 00/00 → code=4. Repeat with the yellow held 3 cycles → no fault.
- MAX_PHASE=5: hold 00/00 → fault=1, code=5 at the edge where dwell would become 6.
- Drive 01/01 and 10/10 in the same cycle as clr_fault while in FAULT → state goes to INIT and fault=0. The following 01/01 sample faults with code=2 and fault_count=2.

Source files
------------

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared constants for the intersection controller and its conflict monitor.
//   - Light codes (2 bits per channel): RED, GREEN, YELLOW; 2'b11 is invalid.
//   - Fault codes (3 bits): FLT_NONE .. FLT_WDOG, lower code = higher priority.
//   - Monitor FSM state encoding: ST_INIT, ST_MONITOR, ST_FAULT.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;
    localparam logic [1:0] BADCODE = 2'b11;

    localparam logic [2:0] FLT_NONE     = 3'd0;
    localparam logic [2:0] FLT_INVALID  = 3'd1;
    localparam logic [2:0] FLT_CONFLICT = 3'd2;
    localparam logic [2:0] FLT_ILLEGAL  = 3'd3;
    localparam logic [2:0] FLT_SHORT_Y  = 3'd4;
    localparam logic [2:0] FLT_WDOG     = 3'd5;

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_MONITOR = 2'd1;
    localparam logic [1:0] ST_FAULT   = 2'd2;

    function automatic logic is_invalid(input logic [1:0] code);
        return code == BADCODE;
    endfunction

endpackage

// File: rtl/traffic_transition_check.sv
// -----------------------------------------------------------------------------
// traffic_transition_check
// Per-channel step check between the previous and the current light code.
// Legal steps: hold, GREEN->YELLOW, YELLOW->RED, RED->GREEN.
//   prev_i    [1:0] light code captured at the previous edge
//   cur_i     [1:0] light code sampled this cycle
//   illegal_o       step is outside the legal set
//   y2r_o           step is YELLOW->RED (caller applies the yellow-length check)
// -----------------------------------------------------------------------------
module traffic_transition_check
    import traffic_pkg::*;
(
    input  logic [1:0] prev_i,
    input  logic [1:0] cur_i,
    output logic       illegal_o,
    output logic       y2r_o
);

    logic legal;

    always_comb begin
        legal = (prev_i == cur_i)
             || ((prev_i == GREEN)  && (cur_i == YELLOW))
             || ((prev_i == YELLOW) && (cur_i == RED))
             || ((prev_i == RED)    && (cur_i == GREEN));
    end

    assign illegal_o = ~legal;
    assign y2r_o     = (prev_i == YELLOW) && (cur_i == RED);

endmodule

// File: rtl/traffic_conflict_monitor.sv
// -----------------------------------------------------------------------------
// traffic_conflict_monitor
// Independent safety monitor on the intersection light outputs. Every cycle the
// {highway,street} sample is checked for invalid codes, conflicting greens,
// illegal steps, short yellows and stuck phases. The first violation latches
// fault/fault_code until clr_fault is pulsed while faulted.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   highway [1:0]     highway light code
//   street  [1:0]     street light code
//   clr_fault         single-cycle clear of a latched fault (FAULT state only)
//   fault             latched fault flag
//   fault_code [2:0]  code of the first violation (0 = none)
//   dwell [CNT_W-1:0] cycles the current combined state has been held (sat.)
//   fault_count       faults latched since reset (sat.), not cleared by clr_fault
//   state_dbg [1:0]   monitor FSM state (ST_INIT / ST_MONITOR / ST_FAULT)
// -----------------------------------------------------------------------------
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 1,
    parameter int MAX_PHASE  = 255,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       highway,
    input  logic [1:0]       street,
    input  logic             clr_fault,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] dwell,
    output logic [CNT_W-1:0] fault_count,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] MIN_Y_C  = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_PH_C = CNT_W'(MAX_PHASE);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [3:0]       prev_q, prev_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             fault_q, fault_d;
    logic [2:0]       code_q, code_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [3:0]       cur;
    logic             ill_hw, ill_st, y2r_hw, y2r_st;
    logic             chk_invalid, chk_conflict, chk_illegal, chk_short, chk_wdog;
    logic [2:0]       init_code, mon_code;
    logic [CNT_W-1:0] dwell_step;
    logic [CNT_W-1:0] count_inc;

    assign cur = {highway, street};

    traffic_transition_check u_hw_check (
        .prev_i    (prev_q[3:2]),
        .cur_i     (highway),
        .illegal_o (ill_hw),
        .y2r_o     (y2r_hw)
    );

    traffic_transition_check u_st_check (
        .prev_i    (prev_q[1:0]),
        .cur_i     (street),
        .illegal_o (ill_st),
        .y2r_o     (y2r_st)
    );

    // All checks compare the current sample with the pre-edge prev/dwell.
    always_comb begin
        chk_invalid  = is_invalid(highway) | is_invalid(street);
        chk_conflict = (highway != RED) && (street != RED);
        chk_illegal  = ill_hw | ill_st;
        chk_short    = (y2r_hw | y2r_st) && (dwell_q < MIN_Y_C);
        chk_wdog     = (cur == prev_q) && (dwell_q == MAX_PH_C);
    end

    // Lowest code wins when several checks fire together.
    always_comb begin
        init_code = FLT_NONE;
        if (chk_invalid)       init_code = FLT_INVALID;
        else if (chk_conflict) init_code = FLT_CONFLICT;

        mon_code = init_code;
        if (init_code == FLT_NONE) begin
            if (chk_illegal)    mon_code = FLT_ILLEGAL;
            else if (chk_short) mon_code = FLT_SHORT_Y;
            else if (chk_wdog)  mon_code = FLT_WDOG;
        end
    end

    always_comb begin
        dwell_step = (cur != prev_q) ? CNT_W'(1)
                   : ((dwell_q == CNT_MAX) ? dwell_q : dwell_q + CNT_W'(1));
        count_inc  = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        prev_d  = cur;
        dwell_d = dwell_step;
        fault_d = fault_q;
        code_d  = code_q;
        count_d = count_q;
        case (state_q)
            ST_INIT: begin
                // No history yet: dwell restarts regardless of prev.
                dwell_d = CNT_W'(1);
                if (init_code != FLT_NONE) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = init_code;
                    count_d = count_inc;
                end else begin
                    state_d = ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (mon_code != FLT_NONE) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = mon_code;
                    count_d = count_inc;
                end
            end
            ST_FAULT: begin
                // A violation in the clearing cycle is deliberately ignored;
                // the next sample is re-checked from INIT.
                if (clr_fault) begin
                    state_d = ST_INIT;
                    fault_d = 1'b0;
                    code_d  = FLT_NONE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            prev_q  <= {RED, RED};
            dwell_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FLT_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            dwell_q <= dwell_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign dwell       = dwell_q;
    assign fault_count = count_q;
    assign state_dbg   = state_q;

endmodule
